uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_arb_pkg.sv | 13 +
 rtl/uart_sync_fifo.sv | 64 ++++++
 rtl/uart_tx_arb.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared defaults and the arbiter FSM state type for the UART TX arbiter.
package uart_arb_pkg;

  localparam int unsigned DefaultNreq  = 4;
  localparam int unsigned DefaultDepth = 16;
  localparam int unsigned DefaultDw    = 32;

  typedef enum logic [0:0] {
    IDLE,
    XFER
  } arb_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; the head word is always on rd_data_o.
module uart_sync_fifo
  import uart_arb_pkg::*;
#(
  parameter int unsigned Depth = DefaultDepth,
  parameter int unsigned Width = DefaultDw,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [Aw:0]      level_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, wr_ptr_d;
  logic [Aw-1:0]    rd_ptr_q, rd_ptr_d;
  logic [Aw:0]      level_q, level_d;
  logic             push, pop;

  assign full_o    = (level_q == (Aw + 1)'(Depth));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Full/empty gate the strobes so overflow and underflow are impossible.
  assign push = wr_en_i & ~full_o;
  assign pop  = rd_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets one requester at a time stream a frame of words into the
// UART TX buffer; a frame ends only when its last word is accepted.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ  = DefaultNreq,
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned DW    = DefaultDw
) (
  input  logic                    clk_125,
  input  logic                    rst_n_125,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ-1:0]         vld_i,
  input  logic [NREQ-1:0]         last_i,
  input  logic [NREQ*DW-1:0]      data_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         rdy_o,
  input  logic                    uart_tx_fifo_rden,
  output logic [DW-1:0]           uart_tx_fifo_data,
  output logic                    uart_tx_fifo_empty,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    busy_o
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_winner_q, last_winner_d;

  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] rr_cand;
  logic            fifo_full;
  logic            push;
  logic            push_last;
  logic [DW-1:0]   push_data;

  // Search starts just after the previous winner, so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_cand    = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      rr_cand = IdxW'((32'(last_winner_q) + i) % NREQ);
      if (!pick_found && req_i[rr_cand]) begin
        pick_found = 1'b1;
        pick_idx   = rr_cand;
      end
    end
  end

  // Only the granted requester can be ready, so its inputs are the only ones looked at.
  assign push      = |(vld_i & rdy_o);
  assign push_last = push & last_i[owner_q];
  assign push_data = data_i[owner_q*DW +: DW];

  always_ff @(posedge clk_125 or negedge rst_n_125) begin
    if (!rst_n_125) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      owner_q       <= '0;
      last_winner_q <= IdxW'(NREQ - 1);
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      owner_q       <= owner_d;
      last_winner_q <= last_winner_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    owner_d       = owner_q;
    last_winner_d = last_winner_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_found) begin
          state_d = XFER;
          gnt_d   = NREQ'(1) << pick_idx;
          owner_d = pick_idx;
        end
      end
      XFER: begin
        if (push_last) begin
          state_d       = IDLE;
          gnt_d         = '0;
          last_winner_d = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    gnt_o  = gnt_q;
    rdy_o  = gnt_q & {NREQ{~fifo_full}};
    busy_o = (state_q == XFER);
  end

  uart_sync_fifo #(
    .Depth (DEPTH),
    .Width (DW)
  ) u_fifo (
    .clk_i     (clk_125),
    .rst_ni    (rst_n_125),
    .wr_en_i   (push),
    .wr_data_i (push_data),
    .rd_en_i   (uart_tx_fifo_rden),
    .rd_data_o (uart_tx_fifo_data),
    .empty_o   (uart_tx_fifo_empty),
    .full_o    (fifo_full),
    .level_o   (fifo_level)
  );

endmodule
